// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit memory-side controller: request decode, byte-lane steering,
// load extraction and BUSY timeout. Macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module lsu_mem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [31:0]         req_wdata,
    output logic                req_ready,
    output logic                stall,
    output logic                done,
    output logic                load_valid,
    output logic [31:0]         load_data,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [1:0]       req_size;
    logic             legal_code;
    logic             req_fault;
    logic             accept;
    logic             expire;
    logic [OFF_W-1:0] off_mask;
    logic [OFF_W-1:0] req_off;
    logic [NB-1:0]    be_nx;
    logic [DATA_W-1:0] wdata_nx;

    logic             we_q;
    logic             uns_q;
    logic             fault_q;
    logic [1:0]       size_q;
    logic [OFF_W-1:0] off_q;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0] lane_bit;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      rd_word;
    logic [31:0]      load_ext;

    // Request decode: legality, natural-alignment offset, lane enables and replicated store data.
    always_comb begin
        req_size   = req_funct3[1:0];
        legal_code = (req_size != 2'b11) &&
                     (req_we ? !req_funct3[2] : (req_funct3 != 3'b110));

        case (req_size)
            SZ_H:    off_mask = ~OFF_W'(1);
            SZ_B:    off_mask = '1;
            default: off_mask = ~OFF_W'(3);
        endcase
        req_off = req_addr[OFF_W-1:0] & off_mask;

`ifdef LSU_MISALIGN_TRAP_EN
        req_fault = !legal_code || ((req_addr[OFF_W-1:0] & ~off_mask) != '0);
`else
        req_fault = !legal_code;
`endif

        case (req_size)
            SZ_B: begin
                be_nx    = NB'(1) << req_off;
                wdata_nx = {NB{req_wdata[7:0]}};
            end
            SZ_H: begin
                be_nx    = NB'(3) << req_off;
                wdata_nx = {(NB/2){req_wdata[15:0]}};
            end
            default: begin
                be_nx    = NB'(15) << req_off;
                wdata_nx = {(NB/4){req_wdata}};
            end
        endcase
    end

    assign accept = req_valid && (state == IDLE);
    assign expire = (cnt == CNT_W'(TIMEOUT - 1));

    // Load extraction from the lane captured at acceptance.
    always_comb begin
        lane_bit = {off_q, 3'b000};
        rd_byte  = mem_rdata[lane_bit +: 8];
        rd_half  = mem_rdata[lane_bit +: 16];
        rd_word  = mem_rdata[lane_bit +: 32];
        case (size_q)
            SZ_B:    load_ext = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
            SZ_H:    load_ext = {{16{rd_half[15] & ~uns_q}}, rd_half};
            default: load_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        stall      = 1'b0;
        mem_req    = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        load_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    state_nx = req_fault ? RESP : BUSY;
                end
            end
            BUSY: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || expire) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                done       = 1'b1;
                err        = fault_q;
                load_valid = !we_q && !fault_q;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            fault_q   <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= '0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        uns_q     <= req_funct3[2];
                        size_q    <= req_size;
                        off_q     <= req_off;
                        fault_q   <= req_fault;
                        cnt       <= '0;
                        load_data <= '0;
                        if (!req_fault) begin
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_be    <= be_nx;
                            mem_wdata <= wdata_nx;
                        end
                    end
                end
                BUSY: begin
                    // An ack on the expiry cycle still completes the access cleanly.
                    if (mem_ack) begin
                        load_data <= we_q ? 32'h0 : load_ext;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                    end else if (expire) begin
                        fault_q   <= 1'b1;
                        load_data <= '0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
module tb_lsu_mem_ctrl;

    typedef struct packed {
        logic        err;
        logic        lv;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_n, req_valid_w;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_ack_n, mem_ack_w;
    logic [63:0] mem_rdata;

    logic        ready_n, stall_n, done_n, lv_n, err_n, mem_req_n, mem_we_n;
    logic [31:0] load_data_n, mem_addr_n, mem_wdata_n;
    logic [3:0]  mem_be_n;
    logic        ready_w, stall_w, done_w, lv_w, err_w, mem_req_w, mem_we_w;
    logic [31:0] load_data_w, mem_addr_w;
    logic [63:0] mem_wdata_w;
    logic [7:0]  mem_be_w;

    logic        wide;
    logic        s_ready, s_stall, s_done, s_req, s_we;
    logic [31:0] s_addr;
    logic [7:0]  s_be;
    logic [63:0] s_wdata;

    resp_t q32[$];
    resp_t q64[$];
    resp_t r32, r64;
    logic [2:0] pulses;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid_n), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(ready_n), .stall(stall_n), .done(done_n), .load_valid(lv_n),
        .load_data(load_data_n), .err(err_n), .mem_req(mem_req_n), .mem_we(mem_we_n),
        .mem_addr(mem_addr_n), .mem_be(mem_be_n), .mem_wdata(mem_wdata_n),
        .mem_ack(mem_ack_n), .mem_rdata(mem_rdata[31:0])
    );

    lsu_mem_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid_w), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(ready_w), .stall(stall_w), .done(done_w), .load_valid(lv_w),
        .load_data(load_data_w), .err(err_w), .mem_req(mem_req_w), .mem_we(mem_we_w),
        .mem_addr(mem_addr_w), .mem_be(mem_be_w), .mem_wdata(mem_wdata_w),
        .mem_ack(mem_ack_w), .mem_rdata(mem_rdata)
    );

    always_comb begin
        if (wide) begin
            s_ready = ready_w;  s_stall = stall_w;  s_done = done_w;
            s_req   = mem_req_w; s_we = mem_we_w;   s_addr = mem_addr_w;
            s_be    = mem_be_w;  s_wdata = mem_wdata_w;
        end else begin
            s_ready = ready_n;  s_stall = stall_n;  s_done = done_n;
            s_req   = mem_req_n; s_we = mem_we_n;   s_addr = mem_addr_n;
            s_be    = {4'b0, mem_be_n}; s_wdata = {32'b0, mem_wdata_n};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitors: every done pulse pops one expected response.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_n) begin
                if (q32.size() == 0) begin
                    check("done32_unexpected", done_n, 0);
                end else begin
                    r32 = q32.pop_front();
                    check("err32", err_n, r32.err);
                    check("load_valid32", lv_n, r32.lv);
                    if (r32.lv || r32.err) check("load_data32", load_data_n, r32.data);
                end
            end else if (err_n || lv_n) begin
                check("pulse32_without_done", {err_n, lv_n}, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done_w) begin
                if (q64.size() == 0) begin
                    check("done64_unexpected", done_w, 0);
                end else begin
                    r64 = q64.pop_front();
                    check("err64", err_w, r64.err);
                    check("load_valid64", lv_w, r64.lv);
                    if (r64.lv || r64.err) check("load_data64", load_data_w, r64.data);
                end
            end else if (err_w || lv_w) begin
                check("pulse64_without_done", {err_w, lv_w}, 0);
            end
        end
    end

    // One access: ack_k = BUSY cycle carrying mem_ack (1 = first), -1 = never ack.
    task automatic access(input string name, input bit w, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [63:0] rd,
                          input int ack_k, input bit exp_req, input logic [31:0] e_addr,
                          input logic [7:0] e_be, input logic [63:0] e_wd,
                          input bit e_err, input logic [31:0] e_data);
        resp_t r;
        int    cnt;
        r.err  = e_err;
        r.lv   = !we && !e_err;
        r.data = e_err ? 32'h0 : e_data;
        wide   = w;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        if (w) req_valid_w = 1'b1; else req_valid_n = 1'b1;
        #1;
        check({name, "_ready"}, s_ready, 1);
        check({name, "_stall_req"}, s_stall, 1);
        if (w) q64.push_back(r); else q32.push_back(r);
        @(negedge clk);
        req_valid_n = 1'b0; req_valid_w = 1'b0;
        if (exp_req) begin
            check({name, "_mem_req"}, s_req, 1);
            check({name, "_mem_addr"}, s_addr, e_addr);
            check({name, "_mem_be"}, s_be, e_be);
            check({name, "_mem_we"}, s_we, we);
            if (we) check({name, "_mem_wdata"}, s_wdata, e_wd);
            if (ack_k < 0) begin
                cnt = 0;
                while (s_req && cnt < 20) begin
                    cnt++;
                    @(negedge clk);
                end
                check({name, "_req_cycles"}, cnt, 4);
            end else begin
                for (int i = 1; i <= ack_k; i++) begin
                    check({name, "_hold_req"}, s_req, 1);
                    check({name, "_hold_be"}, s_be, e_be);
                    mem_rdata = rd;
                    if (w) mem_ack_w = (i == ack_k); else mem_ack_n = (i == ack_k);
                    @(negedge clk);
                end
                mem_ack_n = 1'b0; mem_ack_w = 1'b0;
            end
        end else begin
            check({name, "_no_mem_req"}, s_req, 0);
        end
        check({name, "_done_latency"}, s_done, 1);
        check({name, "_resp_req_low"}, s_req, 0);
        check({name, "_resp_stall"}, s_stall, 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 100000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wide = 1'b0;
        req_valid_n = 1'b0; req_valid_w = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack_n = 1'b0; mem_ack_w = 1'b0;
        mem_rdata = 64'h0; pulses = 3'b0;
        #12;
        check("rst_ready", ready_n, 1);
        check("rst_mem_req", mem_req_n, 0);
        check("rst_pulses", {done_n, err_n, lv_n}, 0);
        check("rst_load_data", load_data_n, 0);
        check("rst_mem_fields", {mem_we_n, mem_be_n, mem_addr_n, mem_wdata_n}, 0);
        @(negedge clk);
        rst = 1'b0;

        access("lb_neg", 0, 0, 3'b000, 32'h1003, 32'h0, 64'h80FF1234, 4, 1, 32'h1000, 8'h08, 64'h0, 0, 32'hFFFFFF80);
        access("lbu",    0, 0, 3'b100, 32'h1003, 32'h0, 64'h80FF1234, 1, 1, 32'h1000, 8'h08, 64'h0, 0, 32'h00000080);
        access("lh_neg", 0, 0, 3'b001, 32'h1002, 32'h0, 64'h80FF1234, 2, 1, 32'h1000, 8'h0C, 64'h0, 0, 32'hFFFF80FF);
        access("lhu",    0, 0, 3'b101, 32'h1000, 32'h0, 64'h80FF1234, 1, 1, 32'h1000, 8'h03, 64'h0, 0, 32'h00001234);
        access("lw",     0, 0, 3'b010, 32'h1000, 32'h0, 64'hDEADBEEF, 3, 1, 32'h1000, 8'h0F, 64'h0, 0, 32'hDEADBEEF);
        access("sb",     0, 1, 3'b000, 32'h1001, 32'h123456A5, 64'h0, 1, 1, 32'h1000, 8'h02, 64'hA5A5A5A5, 0, 32'h0);
        access("sw",     0, 1, 3'b010, 32'h1004, 32'hCAFEF00D, 64'h0, 2, 1, 32'h1004, 8'h0F, 64'hCAFEF00D, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        access("lw_mis", 0, 0, 3'b010, 32'h1002, 32'h0, 64'h0, 1, 0, 32'h0, 8'h00, 64'h0, 1, 32'h0);
        access("lh_mis", 0, 0, 3'b001, 32'h1003, 32'h0, 64'h0, 1, 0, 32'h0, 8'h00, 64'h0, 1, 32'h0);
`else
        access("lw_mis", 0, 0, 3'b010, 32'h1002, 32'h0, 64'h01020304, 1, 1, 32'h1000, 8'h0F, 64'h0, 0, 32'h01020304);
        access("lh_mis", 0, 0, 3'b001, 32'h1003, 32'h0, 64'hAABBCCDD, 1, 1, 32'h1000, 8'h0C, 64'h0, 0, 32'hFFFFAABB);
`endif
        access("ld_bad011", 0, 0, 3'b011, 32'h1000, 32'h0, 64'h0, 1, 0, 32'h0, 8'h00, 64'h0, 1, 32'h0);
        access("ld_bad110", 0, 0, 3'b110, 32'h1000, 32'h0, 64'h0, 1, 0, 32'h0, 8'h00, 64'h0, 1, 32'h0);
        access("st_bad100", 0, 1, 3'b100, 32'h1000, 32'h0, 64'h0, 1, 0, 32'h0, 8'h00, 64'h0, 1, 32'h0);
        access("timeout",   0, 0, 3'b010, 32'h1008, 32'h0, 64'h0, -1, 1, 32'h1008, 8'h0F, 64'h0, 1, 32'h0);
        access("ack_at_expiry", 0, 0, 3'b010, 32'h100C, 32'h0, 64'h55AA55AA, 4, 1, 32'h100C, 8'h0F, 64'h0, 0, 32'h55AA55AA);

        // Reset in the middle of BUSY, then a stray ack after release.
        wide = 1'b0;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1010; req_valid_n = 1'b1;
        @(negedge clk);
        req_valid_n = 1'b0;
        check("rst_test_busy", mem_req_n, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_mem_req", mem_req_n, 0);
        check("rst_async_be", mem_be_n, 0);
        check("rst_async_ready", ready_n, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 3'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ack_n = (i == 2);
            mem_rdata = 64'h77777777;
            @(negedge clk);
            pulses = pulses | {done_n, err_n, lv_n};
        end
        mem_ack_n = 1'b0;
        check("rst_no_pulse", pulses, 0);
        check("rst_idle_ready", ready_n, 1);
        access("post_rst_lw", 0, 0, 3'b010, 32'h1010, 32'h0, 64'h0BADF00D, 1, 1, 32'h1010, 8'h0F, 64'h0, 0, 32'h0BADF00D);

        access("sh64",  1, 1, 3'b001, 32'h2006, 32'h0000ABCD, 64'h0, 1, 1, 32'h2000, 8'hC0, 64'hABCDABCDABCDABCD, 0, 32'h0);
        access("lw64",  1, 0, 3'b010, 32'h2004, 32'h0, 64'h1122334455667788, 2, 1, 32'h2000, 8'hF0, 64'h0, 0, 32'h11223344);
        access("lb64",  1, 0, 3'b000, 32'h2000, 32'h0, 64'h1122334455667788, 1, 1, 32'h2000, 8'h01, 64'h0, 0, 32'hFFFFFF88);
        access("lhu64", 1, 0, 3'b101, 32'h2006, 32'h0, 64'h1122334455667788, 1, 1, 32'h2000, 8'hC0, 64'h0, 0, 32'h00001122);

        repeat (3) @(negedge clk);
        check("q32_drained", q32.size(), 0);
        check("q64_drained", q64.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter DATA_W, 32, memory bus width in bits; legal values are 32 and 64; the number of byte lanes is NB = DATA_W/8.
REQ-002 Parameter ADDR_W, 32, byte-address width.
REQ-003 Parameter TIMEOUT, 255, maximum number of BUSY cycles before the access aborts; legal range is 1..1023.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  1  pipeline presents a load or store.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_funct3  in  3  RV32I width/sign code.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  32  store data, taken from the low-order bytes.
REQ-012 req_ready  out  1  high in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-013 stall  out  1  pipeline hold.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 load_valid  out  1  one-cycle pulse qualifying load_data.
REQ-016 load_data  out  32  extended load result.
REQ-017 err  out  1  one-cycle fault pulse, coincident with done.
REQ-018 mem_req, mem_we  out  1 each  memory request and write enable.
REQ-019 mem_addr  out  ADDR_W  NB-aligned address, with the low log2(NB) bits forced to 0.
REQ-020 mem_be  out  NB  byte enables.
REQ-021 mem_wdata  out  DATA_W  store data, lane-replicated.
REQ-022 mem_ack  in  1  memory completion.
REQ-023 mem_rdata  in  DATA_W  read data, valid on the mem_ack cycle.

Function
REQ-024 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-025 IDLE transitions: on acceptance of a legal request go to BUSY; on acceptance of a faulting request go to RESP; otherwise stay in IDLE.
REQ-026 BUSY transitions: on mem_ack go to RESP; on expiry of the timeout counter go to RESP with a fault; otherwise stay in BUSY.
REQ-027 RESP SHALL return to IDLE unconditionally after one cycle.
REQ-028 On acceptance, all request fields SHALL be registered; mem_req SHALL assert from the first BUSY cycle, and all mem_* outputs SHALL stay stable until mem_ack.
REQ-029 The offset off SHALL be req_addr[log2(NB)-1:0].
REQ-030 mem_be SHALL be: byte accesses (funct3 000/100) one bit at off; halfword accesses (001/101) two bits at off; word accesses (010) four bits at off.
REQ-031 mem_wdata SHALL replicate req_wdata[7:0] (SB), req_wdata[15:0] (SH) or req_wdata (SW) across all lanes.
REQ-032 Load extraction SHALL select the addressed byte, halfword or word of mem_rdata; LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word through.
REQ-033 Any funct3 outside {000,001,010,100,101} for loads, or outside {000,001,010} for stores, SHALL fault without a memory request.
REQ-034 Latency: with acceptance at cycle N and mem_ack at cycle M (M >= N+1), done and load_valid SHALL pulse at cycle M+1; the minimum latency is 2 cycles.
REQ-035 stall SHALL equal (IDLE & req_valid) | BUSY; it is low in RESP.
REQ-036 load_valid SHALL pulse only for loads that complete without a fault; store completions pulse done only.
REQ-037 The timeout counter SHALL clear on entry to BUSY and count BUSY cycles; when it reaches TIMEOUT without mem_ack, mem_req drops and err pulses with done in RESP.
REQ-038 If mem_ack arrives on the same cycle the timeout expires, the ack SHALL win and no fault is raised.
REQ-039 mem_ack received in IDLE or RESP SHALL be ignored.
REQ-040 req_valid presented in BUSY or RESP SHALL not be accepted.
REQ-041 On any fault, load_data SHALL be 0.

Reset
REQ-042 While rst is high, and asynchronously on its assertion, the block SHALL force: state IDLE, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, done 0, load_valid 0, err 0, load_data 0, counter 0; req_ready reads 1.
REQ-043 Reset during BUSY SHALL drop mem_req immediately and abandon the access; a late mem_ack SHALL be ignored per REQ-039.

Configuration
REQ-044 Macro LSU_MISALIGN_TRAP_EN controls misalignment handling.
REQ-045 With LSU_MISALIGN_TRAP_EN defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL go IDLE->RESP, issue no mem_req, and pulse err and done.
REQ-046 Without LSU_MISALIGN_TRAP_EN: the low address bits SHALL be truncated to natural alignment (addr[0] cleared for halfwords, addr[1:0] cleared for words), the access SHALL proceed, and misalignment never raises err.

Verification
REQ-047 LB, DATA_W=32, addr 0x1003, mem_rdata 0x80FF_1234, ack 3 cycles after mem_req -> mem_be 4'b1000; load_data 0xFFFF_FF80; load_valid pulses one cycle after ack.
REQ-048 SH, addr 0x2006, req_wdata 0x0000_ABCD, DATA_W=64 -> mem_addr 0x2000, mem_be 8'b1100_0000, mem_wdata 0xABCD_ABCD_ABCD_ABCD, done pulses, load_valid stays 0.
REQ-049 LW to 0x1002 with the macro defined -> no mem_req, err and done pulse 1 cycle after acceptance; without the macro -> mem_addr 0x1000, mem_be 4'b1111, normal completion.
REQ-050 TIMEOUT=4, mem_ack never asserts -> mem_req high for exactly 4 cycles, then err and done pulse; a repeat run with ack on the 4th BUSY cycle completes without err.
REQ-051 rst asserted mid-BUSY, then mem_ack pulsed 2 cycles after rst release -> mem_req drops asynchronously, no done, load_valid or err pulse, and a new request is accepted normally afterwards.
